// File: rtl/gb_bus_pkg.sv
// Shared definitions for the Game Boy cartridge bus front-end and the mapper behind it:
// region codes, FSM encoding and address-nibble decode.
package gb_bus_pkg;

  localparam logic [2:0] REG_RAMEN   = 3'd0;
  localparam logic [2:0] REG_ROMLO   = 3'd1;
  localparam logic [2:0] REG_ROMHI   = 3'd2;
  localparam logic [2:0] REG_RAMBANK = 3'd3;
  localparam logic [2:0] REG_MODE    = 3'd4;
  localparam logic [2:0] REG_SRAM    = 3'd5;

  // A15-A12 nibbles that select each mapper register window
  localparam logic [3:0] NIB_RAMEN_LO   = 4'h0;
  localparam logic [3:0] NIB_RAMEN_HI   = 4'h1;
  localparam logic [3:0] NIB_ROMLO      = 4'h2;
  localparam logic [3:0] NIB_ROMHI      = 4'h3;
  localparam logic [3:0] NIB_RAMBANK_LO = 4'h4;
  localparam logic [3:0] NIB_RAMBANK_HI = 4'h5;
  localparam logic [3:0] NIB_MODE_LO    = 4'h6;
  localparam logic [3:0] NIB_MODE_HI    = 4'h7;
  localparam logic [3:0] NIB_SRAM_LO    = 4'hA;
  localparam logic [3:0] NIB_SRAM_HI    = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ARMED  = 2'd2,
    ST_COMMIT = 2'd3
  } gb_bus_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] region;
  } gb_bus_decode_t;

  // SRAM window only counts when the cartridge chip select was low
  function automatic gb_bus_decode_t decode_region(input logic [3:0] nib, input logic ce);
    gb_bus_decode_t d;
    d.hit    = 1'b1;
    d.region = REG_RAMEN;
    case (nib)
      NIB_RAMEN_LO, NIB_RAMEN_HI:     d.region = REG_RAMEN;
      NIB_ROMLO:                      d.region = REG_ROMLO;
      NIB_ROMHI:                      d.region = REG_ROMHI;
      NIB_RAMBANK_LO, NIB_RAMBANK_HI: d.region = REG_RAMBANK;
      NIB_MODE_LO, NIB_MODE_HI:       d.region = REG_MODE;
      NIB_SRAM_LO, NIB_SRAM_HI: begin
        d.region = REG_SRAM;
        d.hit    = ~ce;
      end
      default:                        d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gb_bus_sync.sv
// Multi-flop synchronizer for asynchronous cartridge bus inputs, with a
// per-instance reset value so idle-high strobes do not fake a bus cycle.
module gb_bus_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
    end else begin
      chain[0] <= bus;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/gb_bus_write_capture.sv
// Oversamples the Game Boy cartridge bus, filters WR glitches and turns each
// completed CPU write into one region-decoded event behind a valid/ready buffer.
module gb_bus_write_capture
  import gb_bus_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    inputAddress,
  input  logic [7:0]    inputData,
  input  logic          inputWR,
  input  logic          inputRD,
  input  logic          inputCE,
  input  logic          wrReady,
  output logic          wrValid,
  output logic [2:0]    wrRegion,
  output logic [7:0]    wrData,
  output logic          busError,
  output logic          overflow,
  output gb_bus_state_e fsm_state
);

  // Handshake: an event transfers on every clock edge where wrValid and wrReady
  // are both high; wrRegion/wrData are held stable while wrValid waits for wrReady.

  localparam int         STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [3:0] FILT   = 4'(FILTER_CYCLES);

  logic [2:0]  ctrl_s;
  logic [11:0] addr_data_s;
  logic        s_wr, s_rd, s_ce;
  logic [3:0]  s_addr;
  logic [7:0]  s_data;

  gb_bus_sync #(.WIDTH(3), .STAGES(STAGES), .RESET_VAL(3'b111)) u_ctrl_sync (
    .clock  (clock),
    .reset  (reset),
    .bus    ({inputWR, inputRD, inputCE}),
    .synced (ctrl_s)
  );

  gb_bus_sync #(.WIDTH(12), .STAGES(STAGES), .RESET_VAL(12'h000)) u_addr_data_sync (
    .clock  (clock),
    .reset  (reset),
    .bus    ({inputAddress, inputData}),
    .synced (addr_data_s)
  );

  assign s_wr   = ctrl_s[2];
  assign s_rd   = ctrl_s[1];
  assign s_ce   = ctrl_s[0];
  assign s_addr = addr_data_s[11:8];
  assign s_data = addr_data_s[7:0];

  gb_bus_state_e  state;
  logic [3:0]     cnt;
  logic [3:0]     cnt_next;
  logic [3:0]     cap_addr;
  logic [7:0]     cap_data;
  logic           cap_ce;
  logic           conflict;
  gb_bus_decode_t dec;

  assign cnt_next = cnt + 4'd1;
  assign conflict = ~s_rd & ~s_wr;
  assign dec      = decode_region(cap_addr, cap_ce);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      cap_addr <= 4'd0;
      cap_data <= 8'd0;
      cap_ce   <= 1'b1;
      busError <= 1'b0;
      wrValid  <= 1'b0;
      wrRegion <= 3'd0;
      wrData   <= 8'd0;
      overflow <= 1'b0;
    end else begin
      busError <= 1'b0;
      if (wrValid && wrReady) wrValid <= 1'b0;
      // Track every low WR sample so the final one before WR rises is what commits
      if (!s_wr && state != ST_COMMIT) begin
        cap_addr <= s_addr;
        cap_data <= s_data;
        cap_ce   <= s_ce;
      end
      case (state)
        ST_IDLE: begin
          if (!s_wr) begin
            cnt   <= 4'd1;
            state <= (FILT <= 4'd1) ? ST_ARMED : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (conflict) begin
            busError <= 1'b1;
            cnt      <= 4'd0;
            state    <= ST_IDLE;
          end else if (s_wr) begin
            cnt   <= 4'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= (cnt >= FILT) ? FILT : cnt_next;
            if (cnt_next >= FILT) state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (conflict) begin
            busError <= 1'b1;
            cnt      <= 4'd0;
            state    <= ST_IDLE;
          end else if (s_wr) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          cnt   <= 4'd0;
          state <= ST_IDLE;
          if (dec.hit) begin
            if (!wrValid || wrReady) begin
              wrValid  <= 1'b1;
              wrRegion <= dec.region;
              wrData   <= cap_data;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule
